// File: rtl/lut_frame_writer_pkg.sv
// Shared geometry, frame states and status codes for the phase-table writer
// and the read-side steering LUT.
package lut_frame_writer_pkg;

  localparam int LUT_AW = 10;
  localparam int LUT_DW = 5;
  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_BAD = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AHI  = 3'd1,
    ST_ALO  = 3'd2,
    ST_CNT  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5
  } frame_state_e;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // A bad data byte outranks a checksum mismatch.
  function automatic logic [1:0] frame_err(input logic bad, input logic [7:0] acc,
                                           input logic [7:0] chk);
    logic [1:0] code;
    if (bad) begin
      code = ERR_BAD;
    end else if (acc != chk) begin
      code = ERR_CHK;
    end else begin
      code = ERR_OK;
    end
    return code;
  endfunction

endpackage

// File: rtl/lut_frame_writer_if.sv
// Host byte stream, phase-RAM write port and frame status of the writer.
interface lut_frame_writer_if #(
  parameter int AW = lut_frame_writer_pkg::LUT_AW,
  parameter int DW = lut_frame_writer_pkg::LUT_DW
);
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          lock;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [1:0]    err_code;

  modport master (
    output s_data, s_valid, lock,
    input  s_ready, wr_en, wr_addr, wr_data, busy, done, err_code
  );

  modport slave (
    input  s_data, s_valid, lock,
    output s_ready, wr_en, wr_addr, wr_data, busy, done, err_code
  );
endinterface

// File: rtl/lut_frame_timeout.sv
// Idle-gap counter: cleared by load, counts while run, pulses expire on the
// cycle that would bring the count to TIMEOUT.
module lut_frame_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] idle_cnt_r;

  // Idle cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= '0;
    end else if (load) begin
      idle_cnt_r <= '0;
    end else if (run) begin
      idle_cnt_r <= idle_cnt_r + CW'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  assign expire = run && (idle_cnt_r == LAST);

endmodule

// File: rtl/lut_frame_writer.sv
// Write side of the beam-steering phase RAM: parses framed burst writes from
// the host byte link and issues auto-incrementing single-cycle RAM writes.
module lut_frame_writer
  import lut_frame_writer_pkg::*;
#(
  parameter int         AW      = LUT_AW,
  parameter int         DW      = LUT_DW,
  parameter logic [7:0] SYNC    = FRAME_SYNC,
  parameter int         TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  lut_frame_writer_if.slave bus
);

  frame_state_e  state_r, state_s;
  logic          ready_s, accept_s, data_ok_s, expire_s, load_s, run_s;
  logic [AW-1:0] addr_r;
  logic [7:0]    cnt_r;
  logic [7:0]    xor_r;
  logic          bad_r;
  logic          wr_en_r, busy_r, done_r;
  logic [AW-1:0] wr_addr_r;
  logic [DW-1:0] wr_data_r;
  logic [1:0]    err_r;

  assign accept_s = bus.s_valid & ready_s;
  assign load_s   = accept_s | (state_r == ST_IDLE);
  assign run_s    = (state_r != ST_IDLE) & ~accept_s;

  lut_frame_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .run    (run_s),
    .expire (expire_s)
  );

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next frame state: one advance per accepted byte, timeout aborts
  always_comb begin
    state_s = state_r;
    if (expire_s) begin
      state_s = ST_IDLE;
    end else if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.s_data == SYNC) begin
            state_s = ST_AHI;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_AHI:  state_s = ST_ALO;
        ST_ALO:  state_s = ST_CNT;
        ST_CNT:  state_s = ST_DATA;
        ST_DATA: begin
          if (cnt_r == 8'd0) begin
            state_s = ST_CHK;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_CHK:  state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Handshake and byte qualification; lock only gates a new frame start
  always_comb begin
    ready_s   = 1'b1;
    data_ok_s = (bus.s_data[7:DW] == {(8 - DW){1'b0}});
    if (state_r == ST_IDLE) begin
      ready_s = ~bus.lock;
    end else begin
      ready_s = 1'b1;
    end
  end

  // Frame datapath: address/count/checksum capture, RAM write and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r    <= '0;
      cnt_r     <= 8'd0;
      xor_r     <= 8'd0;
      bad_r     <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= ERR_OK;
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= (state_s != ST_IDLE);
      if (expire_s) begin
        done_r <= 1'b1;
        err_r  <= ERR_TMO;
      end else if (accept_s) begin
        case (state_r)
          ST_IDLE: begin
            if (bus.s_data == SYNC) begin
              xor_r <= 8'd0;
              bad_r <= 1'b0;
            end
          end
          ST_AHI: begin
            xor_r  <= chk_fold(xor_r, bus.s_data);
            addr_r <= {bus.s_data[AW-9:0], addr_r[7:0]};
          end
          ST_ALO: begin
            xor_r       <= chk_fold(xor_r, bus.s_data);
            addr_r[7:0] <= bus.s_data;
          end
          ST_CNT: begin
            xor_r <= chk_fold(xor_r, bus.s_data);
            cnt_r <= bus.s_data;
          end
          ST_DATA: begin
            xor_r  <= chk_fold(xor_r, bus.s_data);
            addr_r <= addr_r + AW'(1);
            cnt_r  <= cnt_r - 8'd1;
            // Suppressed bytes still consume an address slot
            if (data_ok_s) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= addr_r;
              wr_data_r <= bus.s_data[DW-1:0];
            end else begin
              bad_r <= 1'b1;
            end
          end
          ST_CHK: begin
            done_r <= 1'b1;
            err_r  <= frame_err(bad_r, xor_r, bus.s_data);
          end
          default: begin
            err_r <= err_r;
          end
        endcase
      end
    end
  end

  assign bus.s_ready  = ready_s;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err_code = err_r;

endmodule

// File: tb/tb_lut_frame_writer.sv
// Self-checking bench for lut_frame_writer: directed frame table, timeout and
// reset sequences, then random frames against a behavioural frame model.
module tb_lut_frame_writer;
  import lut_frame_writer_pkg::*;

  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_frame_writer_if #(.AW(10), .DW(5)) bus();

  lut_frame_writer #(.AW(10), .DW(5), .SYNC(8'hA5), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [14:0] got_w[$];
  int          got_ws[$];
  logic [1:0]  got_err[$];
  int          got_ds[$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      got_w.push_back({bus.wr_addr, bus.wr_data});
      got_ws.push_back(cyc);
    end
    if (bus.done) begin
      got_err.push_back(bus.err_code);
      got_ds.push_back(cyc);
    end
  end

  logic [7:0]  frame[$];
  logic [14:0] exp_w[$];
  logic [1:0]  exp_err;
  int          st[$];

  typedef struct {
    int          len;
    logic [63:0] bytes;
    int          nw;
    logic [44:0] w;
    logic [1:0]  err;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_w.delete(); got_ws.delete(); got_err.delete(); got_ds.delete(); st.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    bus.s_data = b;
    bus.s_valid = 1'b1;
    #1;
    while (!bus.s_ready && tries < 100) begin
      @(negedge clk); #1; tries++;
    end
    if (!bus.s_ready) begin
      check("handshake", {31'd0, bus.s_ready}, 32'd1);
      bus.s_valid = 1'b0;
      st.push_back(-1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    st.push_back(cyc);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int w = 0;
    #1;
    while (got_err.size() == 0 && w < bound) begin
      @(negedge clk); #1; w++;
    end
    check({tag, " done seen"}, {31'd0, got_err.size() != 0}, 32'd1);
    if (got_err.size() != 0) check({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check({tag, " done count"}, got_err.size(), 32'd1);
  endtask

  // Spec-level frame model: expected writes and end-of-frame code.
  task automatic model();
    logic [9:0] a;
    logic [7:0] x;
    logic       bad;
    int         n;
    exp_w.delete();
    a = {frame[1][1:0], frame[2]};
    n = int'(frame[3]) + 1;
    x = frame[1] ^ frame[2] ^ frame[3];
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      x = x ^ frame[4 + i];
      if (frame[4 + i][7:5] == 3'd0) exp_w.push_back({a, frame[4 + i][4:0]});
      else bad = 1'b1;
      a = 10'((int'(a) + 1) % 1024);
    end
    if (bad) exp_err = 2'd1;
    else if (x != frame[4 + n]) exp_err = 2'd2;
    else exp_err = 2'd0;
  endtask

  task automatic run_frame(input int gap_max, input logic lock_mid, input string tag);
    int k;
    logic ok;
    clear_mon();
    for (int i = 0; i < frame.size(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      send_byte(frame[i]);
      if (i == 0 && lock_mid) bus.lock = 1'b1;
    end
    wait_done(50, tag);
    bus.lock = 1'b0;
    if (got_err.size() != 0) begin
      check({tag, " err_code"}, {30'd0, got_err[0]}, {30'd0, exp_err});
      check({tag, " done timing"}, got_ds[0], st[st.size() - 1]);
    end
    check({tag, " write count"}, got_w.size(), exp_w.size());
    for (int j = 0; j < got_w.size() && j < exp_w.size(); j++) begin
      check({tag, " write addr/data"}, {17'd0, got_w[j]}, {17'd0, exp_w[j]});
      k = -1;
      for (int i = 4; i < st.size(); i++) if (st[i] == got_ws[j]) k = i;
      ok = (k >= 4) && (frame[k][4:0] == got_w[j][4:0]);
      check({tag, " write timing"}, {31'd0, ok}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, x, junk;
    int         n;
    vt[0] = '{8, 64'hA501FE020A1F03EB, 3, {10'h1FE, 5'h0A, 10'h1FF, 5'h1F, 10'h200, 5'h03}, 2'd0};
    vt[1] = '{7, 64'hA503FF010506FE00, 2, {10'h3FF, 5'h05, 10'h000, 5'h06, 15'd0}, 2'd0};
    vt[2] = '{6, 64'hA500100025350000, 0, 45'd0, 2'd1};
    vt[3] = '{6, 64'hA500100007000000, 1, {10'h010, 5'h07, 30'd0}, 2'd2};
    vt[4] = '{6, 64'hA5FD40001CA10000, 1, {10'h140, 5'h1C, 30'd0}, 2'd0};
    vt[5] = '{7, 64'hA5000001E002FF00, 1, {10'h001, 5'h02, 30'd0}, 2'd1};

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus.lock = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("reset wr_addr", {22'd0, bus.wr_addr}, 32'd0);
    check("reset wr_data", {27'd0, bus.wr_data}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset err_code", {30'd0, bus.err_code}, 32'd0);
    check("reset s_ready", {31'd0, bus.s_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // lock blocks a new frame start
    bus.lock = 1'b1;
    bus.s_data = 8'hA5;
    bus.s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      check("lock s_ready", {31'd0, bus.s_ready}, 32'd0);
      check("lock busy", {31'd0, bus.busy}, 32'd0);
    end
    bus.s_valid = 1'b0;
    bus.lock = 1'b0;
    @(negedge clk);

    // stray byte in IDLE is dropped
    clear_mon();
    send_byte(8'h3C);
    #1;
    check("stray busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("stray writes", got_w.size(), 32'd0);
    check("stray done", got_err.size(), 32'd0);

    for (int v = 0; v < 6; v++) begin
      frame.delete();
      exp_w.delete();
      for (int i = 0; i < vt[v].len; i++) frame.push_back(vt[v].bytes[63 - 8 * i -: 8]);
      for (int j = 0; j < vt[v].nw; j++) exp_w.push_back(vt[v].w[44 - 15 * j -: 15]);
      exp_err = vt[v].err;
      run_frame(0, 1'b0, $sformatf("vec%0d", v));
    end

    // timeout inside DATA
    clear_mon();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h05); send_byte(8'h11);
    wait_done(TMO + 20, "timeout");
    if (got_err.size() != 0) begin
      check("timeout err_code", {30'd0, got_err[0]}, 32'd3);
      check("timeout latency", got_ds[0], st[4] + TMO);
    end
    check("timeout write count", got_w.size(), 32'd1);
    if (got_w.size() != 0) check("timeout write", {17'd0, got_w[0]}, {17'd0, 10'h020, 5'h11});
    send_byte(8'h12);
    repeat (3) @(negedge clk);
    check("post-timeout writes", got_w.size(), 32'd1);

    // reset mid-DATA with a write pending
    clear_mon();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h30); send_byte(8'h05); send_byte(8'h01);
    check("pre-reset wr_en", {31'd0, bus.wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst wr_addr", {22'd0, bus.wr_addr}, 32'd0);
    check("rst wr_data", {27'd0, bus.wr_data}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst err_code", {30'd0, bus.err_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame.delete();
    for (int i = 0; i < vt[0].len; i++) frame.push_back(vt[0].bytes[63 - 8 * i -: 8]);
    model();
    run_frame(0, 1'b0, "after reset");

    // random frames against the model
    for (int f = 0; f < 50; f++) begin
      if ($urandom_range(3, 0) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      frame.delete();
      frame.push_back(8'hA5);
      frame.push_back(8'($urandom));
      frame.push_back(8'($urandom));
      frame.push_back(8'($urandom_range(6, 0)));
      n = int'(frame[3]) + 1;
      x = frame[1] ^ frame[2] ^ frame[3];
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if ($urandom_range(5, 0) != 0) b[7:5] = 3'b000;
        x = x ^ b;
        frame.push_back(b);
      end
      if ($urandom_range(3, 0) == 0) x = 8'($urandom);
      frame.push_back(x);
      model();
      run_frame(3, 1'($urandom_range(1, 0)), $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
